// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one word request at a time, holds the returned
// instruction for decode, and steers the fetch address on branch/flush redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        id_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_RESET        = 2'd0,
        S_FETCH        = 2'd1,
        S_WAIT_DISCARD = 2'd2,
        S_VALID        = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic        pend_flush, pend_flush_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic [31:0] if_inst_nxt, if_pc_nxt, cnt_nxt;

    logic        redirect;
    logic        mrg_vld, mrg_flush;
    logic [31:0] mrg_tgt;

    // Fold this cycle's redirect into the pending one: flush always wins,
    // a branch may only replace another branch.
    always_comb begin
        redirect  = flush_i | branch_flag_i;
        mrg_vld   = pend_vld;
        mrg_flush = pend_flush;
        mrg_tgt   = pend_tgt;
        if (flush_i) begin
            mrg_vld   = 1'b1;
            mrg_flush = 1'b1;
            mrg_tgt   = {flush_pc_i[31:2], 2'b00};
        end else if (branch_flag_i && !(pend_vld && pend_flush)) begin
            mrg_vld   = 1'b1;
            mrg_flush = 1'b0;
            mrg_tgt   = {branch_target_i[31:2], 2'b00};
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_vld_nxt   = pend_vld;
        pend_flush_nxt = pend_flush;
        pend_tgt_nxt   = pend_tgt;
        if_inst_nxt    = if_inst_o;
        if_pc_nxt      = if_pc_o;
        cnt_nxt        = fetch_cnt_o;

        case (state)
            S_RESET: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    if (redirect) begin
                        pc_nxt         = mrg_tgt;
                        pend_vld_nxt   = 1'b0;
                        pend_flush_nxt = 1'b0;
                    end else if (pend_vld) begin
                        state_nxt = S_WAIT_DISCARD;
                    end else begin
                        if_inst_nxt = imem_rdata_i;
                        if_pc_nxt   = pc;
                        state_nxt   = S_VALID;
                    end
                end else begin
                    // Request must complete at its original address; remember where to go.
                    pend_vld_nxt   = mrg_vld;
                    pend_flush_nxt = mrg_flush;
                    pend_tgt_nxt   = mrg_tgt;
                end
            end
            S_WAIT_DISCARD: begin
                pc_nxt         = mrg_tgt;
                pend_vld_nxt   = 1'b0;
                pend_flush_nxt = 1'b0;
                state_nxt      = S_FETCH;
            end
            S_VALID: begin
                if (redirect) begin
                    pc_nxt    = mrg_tgt;
                    state_nxt = S_FETCH;
                end else if (id_ready_i) begin
                    pc_nxt    = pc + 32'd4;
                    cnt_nxt   = fetch_cnt_o + 32'd1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            pc          <= RESET_PC;
            pend_vld    <= 1'b0;
            pend_flush  <= 1'b0;
            pend_tgt    <= 32'd0;
            if_inst_o   <= 32'd0;
            if_pc_o     <= 32'd0;
            fetch_cnt_o <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_vld    <= pend_vld_nxt;
            pend_flush  <= pend_flush_nxt;
            pend_tgt    <= pend_tgt_nxt;
            if_inst_o   <= if_inst_nxt;
            if_pc_o     <= if_pc_nxt;
            fetch_cnt_o <= cnt_nxt;
        end
    end

    assign imem_req_o  = (state == S_FETCH);
    assign imem_addr_o = pc;
    assign if_valid_o  = (state == S_VALID);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a transaction-level model predicts request starts,
// deliveries and per-cycle status; a monitor compares them against the DUT.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'd0;
    logic        id_ready_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic [31:0] fetch_cnt_o;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .id_ready_i(id_ready_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_inst_o(if_inst_o), .if_pc_o(if_pc_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] cnt; } dlv_t;
    typedef struct { logic req; logic vld; } st_t;

    logic [31:0] rq_q[$];
    dlv_t        dlv_q[$];
    st_t         st_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch unit is doing, described by activity flags.
    logic        m_in_reset = 1'b1, m_requesting = 1'b0, m_holding = 1'b0, m_discard = 1'b0;
    logic        m_pend = 1'b0, m_pend_is_flush = 1'b0;
    logic [31:0] m_pend_tgt = 32'd0, m_pc = RESET_PC, m_cnt = 32'd0;

    task automatic model(input logic r, input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] fp, input logic rd, input logic a);
        logic        np, nf;
        logic [31:0] nt;
        st_t         s;
        dlv_t        d;
        np = m_pend; nf = m_pend_is_flush; nt = m_pend_tgt;
        if (f) begin
            np = 1'b1; nf = 1'b1; nt = fp & ~32'd3;
        end else if (b && !(m_pend && m_pend_is_flush)) begin
            np = 1'b1; nf = 1'b0; nt = bt & ~32'd3;
        end
        if (r) begin
            m_in_reset = 1'b1; m_requesting = 1'b0; m_holding = 1'b0; m_discard = 1'b0;
            m_pend = 1'b0; m_pend_is_flush = 1'b0; m_pend_tgt = 32'd0;
            m_pc = RESET_PC; m_cnt = 32'd0;
        end else if (m_in_reset) begin
            m_in_reset = 1'b0; m_requesting = 1'b1; rq_q.push_back(m_pc);
        end else if (m_discard) begin
            m_discard = 1'b0; m_pc = nt; m_pend = 1'b0; m_pend_is_flush = 1'b0;
            m_requesting = 1'b1; rq_q.push_back(m_pc);
        end else if (m_holding) begin
            if (f || b) begin
                m_holding = 1'b0; m_pc = nt; m_requesting = 1'b1; rq_q.push_back(m_pc);
            end else if (rd) begin
                m_holding = 1'b0; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
                m_requesting = 1'b1; rq_q.push_back(m_pc);
            end
        end else if (m_requesting) begin
            if (a) begin
                if (f || b) begin
                    m_pc = nt; m_pend = 1'b0; m_pend_is_flush = 1'b0; rq_q.push_back(m_pc);
                end else if (m_pend) begin
                    m_discard = 1'b1; m_requesting = 1'b0;
                end else begin
                    m_holding = 1'b1; m_requesting = 1'b0;
                    d.pc = m_pc; d.inst = mem_word(m_pc); d.cnt = m_cnt;
                    dlv_q.push_back(d);
                end
            end else begin
                m_pend = np; m_pend_is_flush = nf; m_pend_tgt = nt;
            end
        end
        s.req = m_requesting; s.vld = m_holding;
        st_q.push_back(s);
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] fp, input logic rd, input logic a);
        @(negedge clk);
        rst = r; branch_flag_i = b; branch_target_i = bt;
        flush_i = f; flush_pc_i = fp; id_ready_i = rd; imem_ack_i = a;
        model(r, b, bt, f, fp, rd, a);
    endtask

    // Monitor
    logic        prev_req = 1'b0, prev_vld = 1'b0;
    logic [31:0] exp_addr = 32'd0;
    dlv_t        exp_hold;

    initial begin
        st_t  s;
        dlv_t d;
        exp_hold.pc = 32'd0; exp_hold.inst = 32'd0; exp_hold.cnt = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() == 0) begin
                chk("status_missing", 32'd0, 32'd1);
            end else begin
                s = st_q.pop_front();
                chk("imem_req_o", {31'd0, imem_req_o}, {31'd0, s.req});
                chk("if_valid_o", {31'd0, if_valid_o}, {31'd0, s.vld});
            end
            if (rst) begin
                chk("rst_addr", imem_addr_o, RESET_PC);
                chk("rst_inst", if_inst_o, 32'd0);
                chk("rst_pc", if_pc_o, 32'd0);
                chk("rst_cnt", fetch_cnt_o, 32'd0);
            end
            if (imem_req_o && (!prev_req || imem_ack_i)) begin
                if (rq_q.size() == 0) begin
                    chk("unexpected_req", imem_addr_o, 32'hXXXX_XXXX);
                end else begin
                    exp_addr = rq_q.pop_front();
                    chk("req_addr", imem_addr_o, exp_addr);
                end
            end else if (imem_req_o) begin
                chk("req_addr_hold", imem_addr_o, exp_addr);
            end
            while (rq_q.size() != 0) begin
                chk("missing_req", imem_addr_o, rq_q.pop_front());
            end
            if (if_valid_o && !prev_vld) begin
                if (dlv_q.size() == 0) begin
                    chk("unexpected_valid", if_pc_o, 32'hXXXX_XXXX);
                end else begin
                    exp_hold = dlv_q.pop_front();
                    chk("if_pc_o", if_pc_o, exp_hold.pc);
                    chk("if_inst_o", if_inst_o, exp_hold.inst);
                    chk("fetch_cnt_o", fetch_cnt_o, exp_hold.cnt);
                end
            end else if (if_valid_o) begin
                chk("hold_pc", if_pc_o, exp_hold.pc);
                chk("hold_inst", if_inst_o, exp_hold.inst);
            end
            while (dlv_q.size() != 0) begin
                d = dlv_q.pop_front();
                chk("missing_valid", if_pc_o, d.pc);
            end
            prev_req = imem_req_o;
            prev_vld = if_valid_o;
        end
    end

    initial begin
        logic        r, b, f, rd, a;
        logic [31:0] bt, fp;
        // Reset then zero-wait streaming with decode always ready.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 1, 1);
        @(posedge clk); #2;
        chk("cnt_after_3", fetch_cnt_o, 32'd3);
        // Decode stall for 5 cycles while holding.
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #2;
        chk("cnt_stall", fetch_cnt_o, 32'd3);
        drive(0, 0, 0, 0, 0, 1, 0);
        // Branch during a slow request.
        drive(0, 1, 32'h0000_1000, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #2;
        chk("branch_req", imem_addr_o, 32'h0000_1000);
        // Flush and branch together while holding.
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 32'h0000_2000, 1, 32'h0000_0180, 0, 0);
        @(posedge clk); #2;
        chk("flush_req", imem_addr_o, 32'h0000_0180);
        chk("flush_cnt", fetch_cnt_o, 32'd4);
        // Wrap of the fetch address.
        drive(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #2;
        chk("wrap_req", imem_addr_o, 32'h0000_0000);
        // Reset mid-request with acks arriving during reset.
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 1);
        drive(1, 1, 32'h40, 1, 32'h80, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #2;
        chk("post_rst_req", imem_addr_o, RESET_PC);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            b  = ($urandom_range(0, 5) == 0);
            f  = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 9) < 7);
            a  = ($urandom_range(0, 1) == 1);
            bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            fp = $urandom;
            drive(r, b, bt, f, fp, rd, a);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("queues_drained", rq_q.size() + dlv_q.size() + st_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port branch_flag_i  in  1  branch redirect request, valid for one cycle.
REQ-005 SHALL have port branch_target_i  in  32  branch target address.
REQ-006 SHALL have port flush_i  in  1  exception/eret redirect request, priority over branch.
REQ-007 SHALL have port flush_pc_i  in  32  flush target address.
REQ-008 SHALL have port id_ready_i  in  1  decode stage accepts the held instruction.
REQ-009 SHALL have port imem_req_o  out  1  instruction memory request.
REQ-010 SHALL have port imem_addr_o  out  32  instruction memory word address.
REQ-011 SHALL have port imem_ack_i  in  1  memory returns data this cycle.
REQ-012 SHALL have port imem_rdata_i  in  32  returned instruction word.
REQ-013 SHALL have port if_valid_o  out  1  if_inst_o/if_pc_o hold a valid instruction.
REQ-014 SHALL have port if_inst_o  out  32  fetched instruction.
REQ-015 SHALL have port if_pc_o  out  32  address of if_inst_o.
REQ-016 SHALL have port fetch_cnt_o  out  32  count of instructions delivered to decode.

Function
REQ-017 SHALL implement states RESET, FETCH, WAIT_DISCARD, VALID.
REQ-018 RESET: imem_req_o=0, if_valid_o=0; first edge with rst low -> FETCH; redirects ignored in RESET.
REQ-019 FETCH: imem_req_o=1, imem_addr_o=pc, address stable until ack; ack -> capture rdata into if_inst_o, pc into if_pc_o -> VALID.
REQ-020 imem_ack_i SHALL be ignored whenever imem_req_o=0.
REQ-021 VALID: if_valid_o=1, imem_req_o=0; id_ready_i=1 with no redirect -> pc<=pc+4, fetch_cnt_o+1, -> FETCH.
REQ-022 Redirect target SHALL be flush_pc_i if flush_i else branch_target_i; bits [1:0] forced to 00.
REQ-023 Redirect in VALID: held instruction dropped (if_valid_o=0 next cycle, no count), pc<=target, -> FETCH.
REQ-024 Redirect in FETCH without ack same cycle: outstanding request completes; pending target stored -> WAIT_DISCARD on ack (data discarded), else stays FETCH with req held at old address until ack.
REQ-025 Redirect in FETCH with ack same cycle: returned data discarded, pc<=target, -> FETCH (new request next cycle).
REQ-026 WAIT_DISCARD: single cycle, imem_req_o=0, pc<=pending target, -> FETCH.
REQ-027 Multiple redirects while pending: flush overwrites any pending target; branch overwrites a pending branch only; branch ignored while flush pending.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_cnt_o wraps modulo 2^32.
REQ-029 Minimum throughput: one instruction per 2 cycles with zero-wait memory (ack in first FETCH cycle).
REQ-030 if_inst_o/if_pc_o SHALL hold unchanged while if_valid_o=1 and id_ready_i=0.

Reset
REQ-031 rst=1 at any edge SHALL force: state RESET, pc=RESET_PC, pending cleared, imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_inst_o=0, if_pc_o=0, fetch_cnt_o=0.
REQ-032 rst asserted mid-request SHALL abandon the request; any later ack before next FETCH ignored.

Verification
REQ-033 rst 1 then 0, ack immediate, id_ready=1 -> req at 0x0, 0x4, 0x8 every 2 cycles; if_pc_o 0x0,0x4,0x8; fetch_cnt_o 3.
REQ-034 id_ready=0 for 5 cycles in VALID -> if_inst_o/if_pc_o stable, no imem_req_o, fetch_cnt_o unchanged.
REQ-035 branch_flag_i with target 0x1000 in FETCH, ack delayed 3 cycles -> req at old address held till ack, data discarded, next req at 0x1000.
REQ-036 flush_i (0x0180) and branch_flag_i (0x2000) same cycle in VALID -> if_valid_o drops, next req at 0x0180, fetch_cnt_o unchanged.
REQ-037 pc=0xFFFF_FFFC delivered with id_ready=1 -> next req at 0x0000_0000.
REQ-038 rst pulsed while in FETCH, ack arrives during RESET -> ignored; first post-reset req at RESET_PC, all outputs reset values.
